// File: rtl/mmu_arbiter_wrr_pkg.sv
// Shared types and helpers for the weighted round-robin DMA request arbiter.
package mmu_arbiter_wrr_pkg;

  localparam int N_OUTSTANDING_DEF = 8;
  localparam int CH_BITS_MAX       = 4;
  localparam int LEN_BITS_MAX      = 32;

  // Ordering record, sized for the widest legal configuration.
  typedef struct packed {
    logic [CH_BITS_MAX-1:0]  id;
    logic [LEN_BITS_MAX-1:0] len;
  } arb_ord_t;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >>> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/mmu_ord_fifo.sv
// First-word-fall-through ordering FIFO; the head entry is visible whenever empty is low.
module mmu_ord_fifo
  import mmu_arbiter_wrr_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int DEPTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] pop_data,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push_s, do_pop_s;

  always_comb begin
    do_push_s = push & (count_q != CNT_FULL);
    do_pop_s  = pop & (count_q != '0);
    wr_ptr_d  = do_push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d  = do_pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    if (do_push_s && !do_pop_s) begin
      count_d = count_q + CNT_ONE;
    end else if (!do_push_s && do_pop_s) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = mem[rd_ptr_q];
  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);

endmodule

// File: rtl/mmu_arbiter_wrr.sv
// Weighted round-robin arbiter of per-region DMA requests with per-channel
// outstanding-credit caps and an ordering record stream for the data mux.
module mmu_arbiter_wrr
  import mmu_arbiter_wrr_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int REQ_BITS      = 96,
  parameter int LEN_BITS      = 28,
  parameter int WGT_BITS      = 4,
  parameter int N_OUTSTANDING = N_OUTSTANDING_DEF,
  parameter int MUX_DEPTH     = 16,
  parameter int CH_BITS       = clog2(N_CH),
  parameter int CNT_BITS      = clog2(N_OUTSTANDING + 1)
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [N_CH-1:0]              s_req_valid,
  output logic [N_CH-1:0]              s_req_ready,
  input  logic [N_CH*REQ_BITS-1:0]     s_req_data,
  input  logic [N_CH*LEN_BITS-1:0]     s_req_len,
  output logic                         m_req_valid,
  input  logic                         m_req_ready,
  output logic [REQ_BITS-1:0]          m_req_data,
  output logic [CH_BITS-1:0]           m_req_id,
  output logic                         m_mux_valid,
  input  logic                         m_mux_ready,
  output logic [CH_BITS-1:0]           m_mux_id,
  output logic [LEN_BITS-1:0]          m_mux_len,
  input  logic [N_CH-1:0]              xfer_done,
  input  logic [N_CH-1:0]              cnfg_en,
  input  logic [N_CH*WGT_BITS-1:0]     cnfg_weight,
  output logic [N_CH-1:0]              stat_busy,
  output logic [N_CH-1:0]              stat_err
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(N_OUTSTANDING);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
  localparam logic [WGT_BITS-1:0] WGT_ONE = WGT_BITS'(1);
  localparam logic [N_CH-1:0]     CH_ONE  = N_CH'(1);

  logic [N_CH-1:0]     elig_s;
  logic                any_s, owner_cont_s, accept_s, found_s;
  logic [CH_BITS-1:0]  sel_s, cand_s;
  logic [CH_BITS-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WGT_BITS-1:0] burst_q, burst_d, cur_wgt_q, cur_wgt_d;
  logic                turn_q, turn_d;
  logic [CNT_BITS-1:0] cnt_q [N_CH];
  logic [CNT_BITS-1:0] cnt_d [N_CH];
  logic                m_req_valid_q, m_req_valid_d;
  logic [REQ_BITS-1:0] m_req_data_q, m_req_data_d;
  logic [CH_BITS-1:0]  m_req_id_q, m_req_id_d;
  logic [N_CH-1:0]     stat_busy_q, stat_busy_d, stat_err_q, stat_err_d;
  logic                fifo_full_s, fifo_empty_s, fifo_pop_s;
  arb_ord_t            push_rec_s, pop_rec_s;

  // Selection: keep the owner while its turn lasts, otherwise search cyclically.
  // Until the first grant after reset no turn is open, so the search includes rr_ptr itself.
  always_comb begin
    int start;
    int idx;
    for (int i = 0; i < N_CH; i++) begin
      elig_s[i] = s_req_valid[i] & cnfg_en[i] & (cnt_q[i] < CNT_MAX);
    end
    any_s        = |elig_s;
    owner_cont_s = turn_q & elig_s[rr_ptr_q] & (burst_q < cur_wgt_q);
    start        = turn_q ? (int'(rr_ptr_q) + 1) : int'(rr_ptr_q);
    found_s      = 1'b0;
    cand_s       = rr_ptr_q;
    for (int k = 0; k < N_CH; k++) begin
      idx = (start + k) % N_CH;
      if (!found_s && elig_s[idx]) begin
        found_s = 1'b1;
        cand_s  = CH_BITS'(idx);
      end else begin
        found_s = found_s;
      end
    end
    sel_s    = owner_cont_s ? rr_ptr_q : cand_s;
    accept_s = any_s & (!m_req_valid_q | m_req_ready) & !fifo_full_s & !areset;
    s_req_ready = accept_s ? (CH_ONE << sel_s) : '0;

    rr_ptr_d  = rr_ptr_q;
    burst_d   = burst_q;
    cur_wgt_d = cur_wgt_q;
    turn_d    = turn_q;
    if (accept_s && owner_cont_s) begin
      burst_d = burst_q + WGT_ONE;
    end else if (accept_s) begin
      rr_ptr_d  = sel_s;
      burst_d   = '0;
      cur_wgt_d = cnfg_weight[sel_s*WGT_BITS +: WGT_BITS];
      turn_d    = 1'b1;
    end else begin
      burst_d = burst_q;
    end
  end

  always_comb begin
    m_req_valid_d = m_req_valid_q;
    m_req_data_d  = m_req_data_q;
    m_req_id_d    = m_req_id_q;
    if (accept_s) begin
      m_req_valid_d = 1'b1;
      m_req_data_d  = s_req_data[sel_s*REQ_BITS +: REQ_BITS];
      m_req_id_d    = sel_s;
    end else if (m_req_ready) begin
      m_req_valid_d = 1'b0;
    end else begin
      m_req_valid_d = m_req_valid_q;
    end

    push_rec_s.id  = CH_BITS_MAX'(sel_s);
    push_rec_s.len = LEN_BITS_MAX'(s_req_len[sel_s*LEN_BITS +: LEN_BITS]);
    fifo_pop_s     = m_mux_ready & !fifo_empty_s;
  end

  // Credits: a grant and a completion on the same channel cancel out.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s_req_ready[i] && !xfer_done[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (!s_req_ready[i] && xfer_done[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
      stat_err_d[i]  = stat_err_q[i] | (xfer_done[i] & (cnt_q[i] == '0));
      stat_busy_d[i] = (cnt_d[i] != '0);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rr_ptr_q      <= '0;
      burst_q       <= '0;
      cur_wgt_q     <= '0;
      turn_q        <= 1'b0;
      m_req_valid_q <= 1'b0;
      m_req_data_q  <= '0;
      m_req_id_q    <= '0;
      stat_busy_q   <= '0;
      stat_err_q    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      burst_q       <= burst_d;
      cur_wgt_q     <= cur_wgt_d;
      turn_q        <= turn_d;
      m_req_valid_q <= m_req_valid_d;
      m_req_data_q  <= m_req_data_d;
      m_req_id_q    <= m_req_id_d;
      stat_busy_q   <= stat_busy_d;
      stat_err_q    <= stat_err_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  mmu_ord_fifo #(
    .DATA_BITS ($bits(arb_ord_t)),
    .DEPTH     (MUX_DEPTH)
  ) u_ord_fifo (
    .clk       (aclk),
    .rst       (areset),
    .push      (accept_s),
    .push_data (push_rec_s),
    .pop       (fifo_pop_s),
    .pop_data  (pop_rec_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Record fields are forced to zero while the FIFO is empty so stale storage never shows.
  assign m_mux_valid = !fifo_empty_s;
  assign m_mux_id    = fifo_empty_s ? '0 : CH_BITS'(pop_rec_s.id);
  assign m_mux_len   = fifo_empty_s ? '0 : LEN_BITS'(pop_rec_s.len);
  assign m_req_valid = m_req_valid_q;
  assign m_req_data  = m_req_data_q;
  assign m_req_id    = m_req_id_q;
  assign stat_busy   = stat_busy_q;
  assign stat_err    = stat_err_q;

endmodule

// File: tb/tb_mmu_arbiter_wrr.sv
// Directed scoreboard bench for mmu_arbiter_wrr: expected grants/records are queued
// as stimulus is driven and compared when the DUT hands them over.
module tb_mmu_arbiter_wrr;

  localparam int N_CH     = 4;
  localparam int REQ_BITS = 96;
  localparam int LEN_BITS = 28;
  localparam int WGT_BITS = 4;
  localparam int CH_BITS  = 2;

  logic                     aclk = 1'b0;
  logic                     areset;
  logic [N_CH-1:0]          s_req_valid, s_req_ready;
  logic [N_CH*REQ_BITS-1:0] s_req_data;
  logic [N_CH*LEN_BITS-1:0] s_req_len;
  logic                     m_req_valid, m_req_ready;
  logic [REQ_BITS-1:0]      m_req_data;
  logic [CH_BITS-1:0]       m_req_id;
  logic                     m_mux_valid, m_mux_ready;
  logic [CH_BITS-1:0]       m_mux_id;
  logic [LEN_BITS-1:0]      m_mux_len;
  logic [N_CH-1:0]          xfer_done, cnfg_en, stat_busy, stat_err;
  logic [N_CH*WGT_BITS-1:0] cnfg_weight;

  typedef struct packed {
    logic [CH_BITS-1:0]  id;
    logic [REQ_BITS-1:0] data;
    logic [LEN_BITS-1:0] len;
  } exp_t;

  exp_t            exp_req_q[$];
  exp_t            exp_mux_q[$];
  int              checks   = 0;
  int              failures = 0;
  int              acc      = 0;
  logic [N_CH-1:0] ready_smp;

  mmu_arbiter_wrr dut (
    .aclk        (aclk),
    .areset      (areset),
    .s_req_valid (s_req_valid),
    .s_req_ready (s_req_ready),
    .s_req_data  (s_req_data),
    .s_req_len   (s_req_len),
    .m_req_valid (m_req_valid),
    .m_req_ready (m_req_ready),
    .m_req_data  (m_req_data),
    .m_req_id    (m_req_id),
    .m_mux_valid (m_mux_valid),
    .m_mux_ready (m_mux_ready),
    .m_mux_id    (m_mux_id),
    .m_mux_len   (m_mux_len),
    .xfer_done   (xfer_done),
    .cnfg_en     (cnfg_en),
    .cnfg_weight (cnfg_weight),
    .stat_busy   (stat_busy),
    .stat_err    (stat_err)
  );

  always #5 aclk = ~aclk;

  function automatic logic [REQ_BITS-1:0] pay(input int ch, input int t);
    return {32'(t), 32'hC0DE_0000 | 32'(ch), ~32'(ch * 7 + t)};
  endfunction

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic set_payload(input int t);
    for (int i = 0; i < N_CH; i++) begin
      s_req_data[i*REQ_BITS +: REQ_BITS] = pay(i, t);
      s_req_len[i*LEN_BITS +: LEN_BITS]  = 28'(t * 16 + i + 1);
    end
  endtask

  task automatic exp_push(input int ch);
    exp_t e;
    e.id   = CH_BITS'(ch);
    e.data = s_req_data[ch*REQ_BITS +: REQ_BITS];
    e.len  = s_req_len[ch*LEN_BITS +: LEN_BITS];
    exp_req_q.push_back(e);
    exp_mux_q.push_back(e);
  endtask

  // Sample at the falling edge what the next rising edge will commit.
  task automatic tick();
    exp_t e;
    @(negedge aclk);
    ready_smp = s_req_ready;
    if (s_req_ready != '0) acc++;
    if (m_req_valid && m_req_ready) begin
      chk("req_expected", 128'(exp_req_q.size() != 0), 128'(1));
      if (exp_req_q.size() != 0) begin
        e = exp_req_q.pop_front();
        chk("req_id", 128'(m_req_id), 128'(e.id));
        chk("req_data", 128'(m_req_data), 128'(e.data));
      end
    end
    if (m_mux_valid && m_mux_ready) begin
      chk("mux_expected", 128'(exp_mux_q.size() != 0), 128'(1));
      if (exp_mux_q.size() != 0) begin
        e = exp_mux_q.pop_front();
        chk("mux_id", 128'(m_mux_id), 128'(e.id));
        chk("mux_len", 128'(m_mux_len), 128'(e.len));
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset      = 1'b1;
    s_req_valid = '0;
    xfer_done   = '0;
    m_req_ready = 1'b0;
    m_mux_ready = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    exp_req_q.delete();
    exp_mux_q.delete();
    acc = 0;
  endtask

  task automatic wait_acc(input int target, input int budget, input string name);
    int n = 0;
    while (acc < target && n < budget) begin
      tick();
      n++;
    end
    chk(name, 128'(acc), 128'(target));
  endtask

  task automatic drain(input string name);
    int n = 0;
    s_req_valid = '0;
    m_req_ready = 1'b1;
    m_mux_ready = 1'b1;
    while ((exp_req_q.size() != 0 || exp_mux_q.size() != 0) && n < 40) begin
      tick();
      n++;
    end
    chk(name, 128'(exp_req_q.size() + exp_mux_q.size()), 128'(0));
    chk({name, "_idle"}, 128'({m_req_valid, m_mux_valid}), 128'(0));
  endtask

  task automatic pulse(input logic [N_CH-1:0] mask);
    xfer_done = mask;
    tick();
    xfer_done = '0;
  endtask

  initial begin
    cnfg_en     = 4'b1111;
    cnfg_weight = '0;
    s_req_data  = '0;
    s_req_len   = '0;
    do_reset();
    chk("rst_m_req_valid", 128'(m_req_valid), 128'(0));
    chk("rst_m_mux_valid", 128'(m_mux_valid), 128'(0));
    chk("rst_s_req_ready", 128'(s_req_ready), 128'(0));
    chk("rst_stat", 128'({stat_busy, stat_err}), 128'(0));

    // Single channel, three back-to-back requests with distinct lengths.
    set_payload(1);
    m_req_ready = 1'b1;
    m_mux_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_req_len[1*LEN_BITS +: LEN_BITS] = 28'(100 + k);
      s_req_valid = 4'b0010;
      exp_push(1);
      tick();
      chk("t1_ready", 128'(ready_smp), 128'(4'b0010));
    end
    s_req_valid = '0;
    drain("t1_drain");
    chk("t1_acc", 128'(acc), 128'(3));
    chk("t1_busy3", 128'(stat_busy), 128'(4'b0010));
    pulse(4'b0010);
    pulse(4'b0010);
    chk("t1_busy1", 128'(stat_busy), 128'(4'b0010));
    pulse(4'b0010);
    chk("t1_busy0", 128'(stat_busy), 128'(4'b0000));
    chk("t1_err", 128'(stat_err), 128'(4'b0000));

    // Weighted round-robin: ch0 weight 2 (three grants per turn), ch2 weight 0.
    do_reset();
    set_payload(2);
    cnfg_weight[0*WGT_BITS +: WGT_BITS] = 4'd2;
    m_req_ready = 1'b1;
    m_mux_ready = 1'b1;
    exp_push(0); exp_push(0); exp_push(0); exp_push(2);
    exp_push(0); exp_push(0); exp_push(0); exp_push(2);
    s_req_valid = 4'b0101;
    wait_acc(8, 30, "t2_acc");
    s_req_valid = '0;
    drain("t2_drain");
    cnfg_weight = '0;

    // Credit cap on ch3: eight grants, then one more per completion.
    do_reset();
    set_payload(3);
    m_req_ready = 1'b1;
    m_mux_ready = 1'b1;
    for (int k = 0; k < 8; k++) exp_push(3);
    s_req_valid = 4'b1000;
    repeat (12) tick();
    chk("t3_acc8", 128'(acc), 128'(8));
    chk("t3_blocked", 128'(ready_smp), 128'(0));
    pulse(4'b1000);
    exp_push(3);
    repeat (4) tick();
    chk("t3_acc9", 128'(acc), 128'(9));
    chk("t3_blocked_again", 128'(ready_smp), 128'(0));
    drain("t3_drain");

    // Ordering FIFO backpressure: 16 records fill it, the 17th request stalls.
    do_reset();
    set_payload(4);
    m_req_ready = 1'b1;
    m_mux_ready = 1'b0;
    for (int k = 0; k < 16; k++) exp_push(k % 4);
    s_req_valid = 4'b1111;
    wait_acc(16, 40, "t4_acc16");
    m_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_stall_ready", 128'(ready_smp), 128'(0));
      chk("t4_hold_valid", 128'(m_req_valid), 128'(1));
      chk("t4_hold_id", 128'(m_req_id), 128'(3));
      chk("t4_hold_data", 128'(m_req_data), 128'(pay(3, 4)));
    end
    m_req_ready = 1'b1;
    tick();
    chk("t4_full_ready", 128'(ready_smp), 128'(0));
    m_mux_ready = 1'b1;
    tick();
    chk("t4_pop_same_cycle", 128'(ready_smp), 128'(0));
    m_mux_ready = 1'b0;
    exp_push(0);
    tick();
    chk("t4_after_pop", 128'(ready_smp), 128'(4'b0001));
    chk("t4_acc17", 128'(acc), 128'(17));
    s_req_valid = '0;
    drain("t4_drain");

    // Grant and completion on ch1 in one cycle; completion on idle ch2.
    do_reset();
    set_payload(5);
    m_req_ready = 1'b1;
    m_mux_ready = 1'b1;
    exp_push(1); exp_push(1);
    s_req_valid = 4'b0010;
    wait_acc(2, 10, "t5_acc2");
    s_req_valid = 4'b0010;
    xfer_done   = 4'b0010;
    exp_push(1);
    tick();
    chk("t5_grant_done", 128'(ready_smp), 128'(4'b0010));
    s_req_valid = '0;
    xfer_done   = '0;
    drain("t5_drain");
    pulse(4'b0010);
    chk("t5_busy_after1", 128'(stat_busy), 128'(4'b0010));
    pulse(4'b0010);
    chk("t5_busy_after2", 128'(stat_busy), 128'(4'b0000));
    chk("t5_no_err", 128'(stat_err), 128'(4'b0000));
    pulse(4'b0100);
    chk("t5_err_set", 128'(stat_err), 128'(4'b0100));
    repeat (3) tick();
    chk("t5_err_sticky", 128'(stat_err), 128'(4'b0100));
    chk("t5_err_no_busy", 128'(stat_busy), 128'(4'b0000));
    do_reset();
    chk("t5_err_cleared", 128'(stat_err), 128'(4'b0000));

    // Asynchronous reset with a held output and five queued records.
    set_payload(6);
    m_req_ready = 1'b1;
    m_mux_ready = 1'b0;
    exp_push(0); exp_push(1); exp_push(2); exp_push(3); exp_push(0);
    s_req_valid = 4'b1111;
    wait_acc(5, 20, "t6_acc5");
    s_req_valid = '0;
    m_req_ready = 1'b0;
    chk("t6_pre_valid", 128'({m_req_valid, m_mux_valid}), 128'(2'b11));
    areset      = 1'b1;
    s_req_valid = 4'b1111;
    #2;
    chk("t6_rst_req", 128'({m_req_valid, m_req_id}), 128'(0));
    chk("t6_rst_data", 128'(m_req_data), 128'(0));
    chk("t6_rst_mux", 128'({m_mux_valid, m_mux_id, m_mux_len}), 128'(0));
    chk("t6_rst_ready", 128'(s_req_ready), 128'(0));
    chk("t6_rst_stat", 128'({stat_busy, stat_err}), 128'(0));
    @(posedge aclk);
    #1;
    areset = 1'b0;
    exp_req_q.delete();
    exp_mux_q.delete();
    acc = 0;
    m_req_ready = 1'b1;
    m_mux_ready = 1'b1;
    exp_push(0);
    tick();
    chk("t6_first_grant", 128'(ready_smp), 128'(4'b0001));
    s_req_valid = '0;
    drain("t6_drain");
    pulse(4'b0010);
    chk("t6_stale_done_err", 128'(stat_err), 128'(4'b0010));
    chk("t6_busy", 128'(stat_busy), 128'(4'b0001));
    pulse(4'b0001);
    chk("t6_busy_clear", 128'(stat_busy), 128'(4'b0000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
